// File: rtl/xy_switch_allocator.sv
// ---------------------------------------------------------------------------
// xy_switch_allocator
//
// Switch allocator for a 5-port 2D-mesh router tile. The port numbering is
// 0=Local, 1=North, 2=East, 3=South, 4=West and applies to inputs and outputs
// alike.
//
// Each input head flit is routed in XY dimension order. Every output runs an
// independent round-robin arbiter over the inputs that request it. A granted
// output stays locked to its owner until the owner's tail flit transfers
// (wormhole). The flit datapath mux sits outside this block. This block
// drives only the crossbar select lines and the valid/ready handshakes.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   [4:0]  flit valid per input port
//   in_last    [4:0]  tail-flit marker per input port
//   in_dest_x  [5*COORD_W-1:0]  destination X per input (port i at i*COORD_W)
//   in_dest_y  [5*COORD_W-1:0]  destination Y per input, same packing
//   in_ready   [4:0]  input flit accepted when in_valid & in_ready
//   out_valid  [4:0]  flit valid per output port
//   out_ready  [4:0]  downstream ready per output port
//   out_sel    [14:0] crossbar select, 3 bits per output (output o at 3*o)
//   out_busy   [4:0]  output locked to an owner
// ---------------------------------------------------------------------------
module xy_switch_allocator #(
   parameter int COORD_W = 4,
   parameter int MY_X    = 2,
   parameter int MY_Y    = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [4:0]           in_valid,
   input  logic [4:0]           in_last,
   input  logic [5*COORD_W-1:0] in_dest_x,
   input  logic [5*COORD_W-1:0] in_dest_y,
   output logic [4:0]           in_ready,
   output logic [4:0]           out_valid,
   input  logic [4:0]           out_ready,
   output logic [14:0]          out_sel,
   output logic [4:0]           out_busy
);

   localparam int NP = 5;

   localparam logic [COORD_W-1:0] MY_X_C = COORD_W'(MY_X);
   localparam logic [COORD_W-1:0] MY_Y_C = COORD_W'(MY_Y);

   localparam logic [2:0] PORT_LOCAL = 3'd0;
   localparam logic [2:0] PORT_NORTH = 3'd1;
   localparam logic [2:0] PORT_EAST  = 3'd2;
   localparam logic [2:0] PORT_SOUTH = 3'd3;
   localparam logic [2:0] PORT_WEST  = 3'd4;

   // Reduces a value in 0..9 to 0..4. This keeps round-robin indices in range.
   function automatic logic [2:0] wrap5(input logic [3:0] v);
      logic [3:0] r;
      r = (v >= 4'd5) ? (v - 4'd5) : v;
      return r[2:0];
   endfunction

   // Per-output registered state, gathered into module-level views.
   logic [NP-1:0] lock_vec;
   logic [2:0]    owner_vec [NP];

   // Combinational helpers.
   logic [2:0]    route [NP];
   logic [NP-1:0] owns;
   logic [NP-1:0] head;
   logic [NP-1:0] owner_valid;
   logic [NP-1:0] owner_last;

   genvar gi;

   // -----------------------------------------------------------------------
   // XY route per input. X is resolved first. Y is resolved only once X
   // matches this tile's column.
   // -----------------------------------------------------------------------
   generate
      for (gi = 0; gi < NP; gi++) begin : g_route
         logic [COORD_W-1:0] dx;
         logic [COORD_W-1:0] dy;

         assign dx = in_dest_x[gi*COORD_W +: COORD_W];
         assign dy = in_dest_y[gi*COORD_W +: COORD_W];

         assign route[gi] = (dx > MY_X_C) ? PORT_EAST  :
                            (dx < MY_X_C) ? PORT_WEST  :
                            (dy > MY_Y_C) ? PORT_NORTH :
                            (dy < MY_Y_C) ? PORT_SOUTH :
                                            PORT_LOCAL;
      end
   endgenerate

   // -----------------------------------------------------------------------
   // An input that already owns a locked output is mid-packet. Its flits
   // are body flits whatever in_dest_* carries, so it must not request
   // again.
   // -----------------------------------------------------------------------
   always_comb begin
      owns = '0;
      for (int o = 0; o < NP; o++) begin
         for (int i = 0; i < NP; i++) begin
            if (lock_vec[o] && (owner_vec[o] == 3'(i))) begin
               owns[i] = 1'b1;
            end
         end
      end
   end

   assign head = in_valid & ~owns;

   // -----------------------------------------------------------------------
   // Transfer-phase views of each output's owner. in_ready is built from
   // lock, owner and out_ready only. It never looks at in_valid.
   // -----------------------------------------------------------------------
   always_comb begin
      owner_valid = '0;
      owner_last  = '0;
      in_ready    = '0;
      for (int o = 0; o < NP; o++) begin
         for (int i = 0; i < NP; i++) begin
            if (owner_vec[o] == 3'(i)) begin
               owner_valid[o] = in_valid[i];
               owner_last[o]  = in_last[i];
               if (lock_vec[o] && out_ready[o]) begin
                  in_ready[i] = 1'b1;
               end
            end
         end
      end
   end

   assign out_valid = lock_vec & owner_valid;
   assign out_busy  = lock_vec;

   // -----------------------------------------------------------------------
   // Per-output lock state and round-robin arbiter.
   // -----------------------------------------------------------------------
   generate
      for (gi = 0; gi < NP; gi++) begin : g_out
         logic [NP-1:0] req;
         logic          lock_reg;
         logic          lock_next;
         logic [2:0]    owner_reg;
         logic [2:0]    owner_next;
         logic [2:0]    rr_reg;
         logic [2:0]    rr_next;
         logic          found;
         logic [2:0]    pick;
         logic          release_now;

         always_comb begin
            req = '0;
            for (int i = 0; i < NP; i++) begin
               req[i] = head[i] && (route[i] == 3'(gi));
            end
         end

         // Search starts at rr_reg and wraps. The first requester found wins.
         always_comb begin
            found = 1'b0;
            pick  = 3'd0;
            for (int k = 0; k < NP; k++) begin
               if (!found && req[wrap5({1'b0, rr_reg} + 4'(k))]) begin
                  found = 1'b1;
                  pick  = wrap5({1'b0, rr_reg} + 4'(k));
               end
            end
         end

         // The tail transfers this cycle.
         assign release_now = lock_reg & out_valid[gi] & out_ready[gi] & owner_last[gi];

         // Arbitration looks only at IDLE outputs. An output released at an
         // edge therefore sits idle for one cycle before its next grant.
         always_comb begin
            lock_next  = lock_reg;
            owner_next = owner_reg;
            rr_next    = rr_reg;
            if (lock_reg) begin
               if (release_now) begin
                  lock_next = 1'b0;
               end
            end else if (found) begin
               lock_next  = 1'b1;
               owner_next = pick;
               rr_next    = wrap5({1'b0, pick} + 4'd1);
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               lock_reg  <= 1'b0;
               owner_reg <= 3'd0;
               rr_reg    <= 3'd0;
            end else begin
               lock_reg  <= lock_next;
               owner_reg <= owner_next;
               rr_reg    <= rr_next;
            end
         end

         assign lock_vec[gi]       = lock_reg;
         assign owner_vec[gi]      = owner_reg;
         assign out_sel[3*gi +: 3] = lock_reg ? owner_reg : 3'd0;
      end
   endgenerate

endmodule
